// File: rtl/wb_gpio_pkg.sv
// Shared constants, register decode and byte-lane helpers for the
// Wishbone GPIO/interrupt bridge.
package wb_gpio_pkg;

    localparam logic [7:0] OFF_OUT  = 8'h00;
    localparam logic [7:0] OFF_OEB  = 8'h08;
    localparam logic [7:0] OFF_IN   = 8'h10;
    localparam logic [7:0] OFF_IE   = 8'h18;
    localparam logic [7:0] OFF_IS   = 8'h20;
    localparam logic [7:0] OFF_POL  = 8'h28;
    localparam logic [7:0] OFF_INFO = 8'h30;

    localparam logic [63:0] OEB_RST = '1;
    localparam logic [63:0] POL_RST = '1;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_OUT,
        REG_OEB,
        REG_IN,
        REG_IE,
        REG_IS,
        REG_POL,
        REG_INFO
    } reg_sel_e;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    function automatic logic [31:0] apply_sel(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  sel);
        logic [31:0] m;
        m = lane_mask(sel);
        return (cur & ~m) | (wdata & m);
    endfunction

    function automatic logic [63:0] write_half(input logic [63:0] cur,
                                               input logic        hi,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  sel);
        if (hi)
            return {apply_sel(cur[63:32], wdata, sel), cur[31:0]};
        return {cur[63:32], apply_sel(cur[31:0], wdata, sel)};
    endfunction

    function automatic logic [31:0] pick_half(input logic [63:0] v, input logic hi);
        return hi ? v[63:32] : v[31:0];
    endfunction

    // Bits i with i % n == k feed interrupt line k.
    function automatic logic [63:0] group_mask(input int unsigned k, input int unsigned n);
        logic [63:0] m;
        m = '0;
        for (int unsigned i = 0; i < 64; i++)
            if (i % n == k)
                m[i] = 1'b1;
        return m;
    endfunction

    // Decodes a word-aligned offset; bit 2 selects the HI half and is ignored here.
    function automatic reg_sel_e decode_reg(input logic [7:0] off);
        reg_sel_e r;
        case ({off[7:3], 3'b000})
            OFF_OUT:  r = REG_OUT;
            OFF_OEB:  r = REG_OEB;
            OFF_IN:   r = REG_IN;
            OFF_IE:   r = REG_IE;
            OFF_IS:   r = REG_IS;
            OFF_POL:  r = REG_POL;
            OFF_INFO: r = off[2] ? REG_NONE : REG_INFO;
            default:  r = REG_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gpio_edge_sync.sv
// Per-pin input synchroniser, previous-sample flop and polarity-selectable
// edge detector.
module gpio_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    input  logic pol,
    output logic sync,
    output logic edge_det
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pad};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync     = chain[SYNC_STAGES-1];
    assign edge_det = pol ? (sync & ~prev) : (~sync & prev);

endmodule

// File: rtl/wb_gpio_irq_bridge.sv
// Wishbone-slave GPIO register bank with synchronised inputs, per-pin edge
// interrupts (sticky W1C status) and grouped user_irq outputs.
module wb_gpio_irq_bridge
    import wb_gpio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int unsigned N_IO        = 38,
    parameter int unsigned N_IRQ       = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic [31:0]       wbs_dat_o,
    output logic              wbs_ack_o,
    input  logic [N_IO-1:0]   io_in,
    output logic [N_IO-1:0]   io_out,
    output logic [N_IO-1:0]   io_oeb,
    output logic [N_IRQ-1:0]  user_irq
);

    localparam logic [63:0] IO_MASK = (N_IO >= 64) ? '1 : ((64'd1 << N_IO) - 64'd1);

    logic [63:0] out_q, oeb_q, ie_q, is_q, pol_q;
    logic [63:0] in_sync, edges, clr, is_next;
    logic [N_IO-1:0] sync_s, edge_raw;
    logic [N_IRQ-1:0] irq_next;
    logic [31:0] rdata;
    logic        req, hit, hi, rd_cycle, wr_commit, primed;
    logic [2:0]  fill_cnt;
    reg_sel_e    reg_sel;

    for (genvar g = 0; g < N_IO; g++) begin : g_pin
        gpio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk      (wb_clk_i),
            .rst      (wb_rst_i),
            .pad      (io_in[g]),
            .pol      (pol_q[g]),
            .sync     (sync_s[g]),
            .edge_det (edge_raw[g])
        );
    end

    assign in_sync = 64'(sync_s);

    assign req       = wbs_cyc_i & wbs_stb_i;
    assign hit       = req & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign hi        = wbs_adr_i[2];
    assign reg_sel   = (hit && wbs_adr_i[1:0] == 2'b00) ? decode_reg(wbs_adr_i[7:0]) : REG_NONE;
    assign rd_cycle  = req & ~wbs_ack_o & ~wbs_we_i;
    assign wr_commit = req & wbs_ack_o & wbs_we_i;

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_OUT:  rdata = pick_half(out_q, hi);
            REG_OEB:  rdata = pick_half(oeb_q, hi);
            REG_IN:   rdata = pick_half(in_sync, hi);
            REG_IE:   rdata = pick_half(ie_q, hi);
            REG_IS:   rdata = pick_half(is_q, hi);
            REG_POL:  rdata = pick_half(pol_q, hi);
            REG_INFO: rdata = {8'd0, 8'(N_IRQ), 8'd0, 8'(N_IO)};
            default:  rdata = '0;
        endcase
    end

    // An edge landing in the same cycle as a W1C of that bit keeps the bit set.
    always_comb begin
        clr = '0;
        if (wr_commit && reg_sel == REG_IS)
            clr = (hi ? {wbs_dat_i & lane_mask(wbs_sel_i), 32'h0}
                      : {32'h0, wbs_dat_i & lane_mask(wbs_sel_i)}) & IO_MASK;
        edges   = primed ? 64'(edge_raw) : '0;
        is_next = (is_q & ~clr) | edges;
    end

    for (genvar k = 0; k < N_IRQ; k++) begin : g_irq
        assign irq_next[k] = |(is_q & ie_q & group_mask(k, N_IRQ));
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            primed   <= 1'b0;
            fill_cnt <= '0;
        end else if (!primed) begin
            if (fill_cnt == 3'(SYNC_STAGES))
                primed <= 1'b1;
            else
                fill_cnt <= fill_cnt + 3'd1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            out_q     <= '0;
            oeb_q     <= OEB_RST & IO_MASK;
            ie_q      <= '0;
            is_q      <= '0;
            pol_q     <= POL_RST & IO_MASK;
            user_irq  <= '0;
        end else begin
            wbs_ack_o <= req & ~wbs_ack_o;
            wbs_dat_o <= rd_cycle ? rdata : '0;
            if (wr_commit) begin
                case (reg_sel)
                    REG_OUT: out_q <= write_half(out_q, hi, wbs_dat_i, wbs_sel_i) & IO_MASK;
                    REG_OEB: oeb_q <= write_half(oeb_q, hi, wbs_dat_i, wbs_sel_i) & IO_MASK;
                    REG_IE:  ie_q  <= write_half(ie_q,  hi, wbs_dat_i, wbs_sel_i) & IO_MASK;
                    REG_POL: pol_q <= write_half(pol_q, hi, wbs_dat_i, wbs_sel_i) & IO_MASK;
                    default: ;
                endcase
            end
            is_q     <= is_next;
            user_irq <= irq_next;
        end
    end

    assign io_out = out_q[N_IO-1:0];
    assign io_oeb = oeb_q[N_IO-1:0];

endmodule

// File: tb/tb_wb_gpio_irq_bridge.sv
// Scoreboard bench for wb_gpio_irq_bridge: directed scenarios plus random bus
// traffic and pad activity, checked against a behavioural register model.
module tb_wb_gpio_irq_bridge;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int S = 2;
    localparam logic [63:0] VALID = 64'h0000_003F_FFFF_FFFF;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = '0;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic [37:0] io_in = '0;
    logic [37:0] io_out, io_oeb;
    logic [2:0]  user_irq;

    int checks = 0;
    int failures = 0;

    wb_gpio_irq_bridge #(.BASE_ADDR(BASE), .N_IO(38), .N_IRQ(3), .SYNC_STAGES(S)) dut (
        .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
        .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .user_irq(user_irq)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] m_out, m_oeb, m_ie, m_is, m_pol, m_edges, m_clr;
    logic [2:0]  m_irq, m_nextirq;
    logic        m_ack, m_req, m_hit;
    logic [37:0] ph [0:S];          // ph[k] = pad value sampled k+1 edges ago
    int          n_edges;
    logic [31:0] exp_q[$];

    function automatic logic [63:0] put_lanes(input logic [63:0] r, input int h,
                                              input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) r[h*32 + b*8 +: 8] = d[b*8 +: 8];
        return r & VALID;
    endfunction

    function automatic logic [63:0] w1c_bits(input int h, input logic [31:0] d, input logic [3:0] s);
        logic [63:0] c;
        c = '0;
        for (int b = 0; b < 4; b++)
            if (s[b]) c[h*32 + b*8 +: 8] = d[b*8 +: 8];
        return c & VALID;
    endfunction

    function automatic logic [31:0] ref_read(input logic [7:0] off);
        logic [63:0] insync;
        insync = {26'd0, ph[S-1]};
        case (off)
            8'h00: return m_out[31:0];   8'h04: return m_out[63:32];
            8'h08: return m_oeb[31:0];   8'h0C: return m_oeb[63:32];
            8'h10: return insync[31:0];  8'h14: return insync[63:32];
            8'h18: return m_ie[31:0];    8'h1C: return m_ie[63:32];
            8'h20: return m_is[31:0];    8'h24: return m_is[63:32];
            8'h28: return m_pol[31:0];   8'h2C: return m_pol[63:32];
            8'h30: return 32'h0003_0026;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            m_out = '0; m_oeb = VALID; m_ie = '0; m_is = '0; m_pol = VALID;
            m_irq = '0; m_ack = 1'b0; n_edges = 0;
            for (int k = 0; k <= S; k++) ph[k] = '0;
            exp_q.delete();
        end else begin
            n_edges++;
            m_req = wbs_cyc_i & wbs_stb_i;
            m_hit = m_req && wbs_adr_i[31:8] == BASE[31:8] && wbs_adr_i[1:0] == 2'b00;
            m_edges = '0;
            if (n_edges >= S + 2)
                for (int i = 0; i < 38; i++) begin
                    if (m_pol[i]) m_edges[i] = ph[S-1][i] && !ph[S][i];
                    else          m_edges[i] = !ph[S-1][i] && ph[S][i];
                end
            m_nextirq = '0;
            for (int i = 0; i < 38; i++)
                if (m_is[i] && m_ie[i]) m_nextirq[i % 3] = 1'b1;
            if (m_req && !m_ack)
                exp_q.push_back((!wbs_we_i && m_hit) ? ref_read(wbs_adr_i[7:0]) : 32'h0);
            m_clr = '0;
            if (m_req && m_ack && wbs_we_i && m_hit)
                case (wbs_adr_i[7:0])
                    8'h00: m_out = put_lanes(m_out, 0, wbs_dat_i, wbs_sel_i);
                    8'h04: m_out = put_lanes(m_out, 1, wbs_dat_i, wbs_sel_i);
                    8'h08: m_oeb = put_lanes(m_oeb, 0, wbs_dat_i, wbs_sel_i);
                    8'h0C: m_oeb = put_lanes(m_oeb, 1, wbs_dat_i, wbs_sel_i);
                    8'h18: m_ie  = put_lanes(m_ie,  0, wbs_dat_i, wbs_sel_i);
                    8'h1C: m_ie  = put_lanes(m_ie,  1, wbs_dat_i, wbs_sel_i);
                    8'h20: m_clr = w1c_bits(0, wbs_dat_i, wbs_sel_i);
                    8'h24: m_clr = w1c_bits(1, wbs_dat_i, wbs_sel_i);
                    8'h28: m_pol = put_lanes(m_pol, 0, wbs_dat_i, wbs_sel_i);
                    8'h2C: m_pol = put_lanes(m_pol, 1, wbs_dat_i, wbs_sel_i);
                    default: ;
                endcase
            m_is  = (m_is & ~m_clr) | m_edges;
            m_irq = m_nextirq;
            m_ack = m_req & ~m_ack;
            for (int k = S; k > 0; k--) ph[k] = ph[k-1];
            ph[0] = io_in;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge wb_clk_i) begin
        if (!wb_rst_i) begin
            if (wbs_ack_o || m_ack) check("ack", wbs_ack_o, m_ack);
            if (wbs_ack_o) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL dat_o unexpected ack, actual=%h expected=none", wbs_dat_o);
                end else
                    check("dat_o", wbs_dat_o, exp_q.pop_front());
            end else
                check("dat_idle", wbs_dat_o, 64'h0);
            check("user_irq", user_irq, m_irq);
            check("io_out", io_out, m_out[37:0]);
            check("io_oeb", io_oeb, m_oeb[37:0]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output int lat);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = w;
        wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = s;
        lat = 0; rd = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge wb_clk_i);
            if (wbs_ack_o) begin lat = c; rd = wbs_dat_o; break; end
        end
        if (lat == 0) begin
            checks++; failures++;
            $display("FAIL ack_timeout addr=%h actual=none required=ack", a);
        end
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd; int lat;
        xfer(1'b1, BASE + off, d, s, rd, lat);
    endtask

    task automatic rd_expect(input string name, input logic [31:0] off, input logic [31:0] exp);
        logic [31:0] rd; int lat;
        xfer(1'b0, BASE + off, 32'h0, 4'hF, rd, lat);
        check(name, rd, exp);
    endtask

    task automatic do_reset();
        #2 wb_rst_i = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        #2 wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
    endtask

    initial begin
        logic [31:0] rd;
        logic [63:0] r64;
        int lat;

        #1 wb_rst_i = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        check("rst_io_oeb", io_oeb, 64'h3F_FFFF_FFFF);
        check("rst_user_irq", user_irq, 64'h0);
        check("rst_ack", wbs_ack_o, 64'h0);
        #2 wb_rst_i = 1'b0;
        repeat (2) @(negedge wb_clk_i);

        rd_expect("oeb_lo", 32'h08, 32'hFFFF_FFFF);
        rd_expect("oeb_hi", 32'h0C, 32'h0000_003F);
        rd_expect("info",   32'h30, 32'h0003_0026);
        rd_expect("pol_hi", 32'h2C, 32'h0000_003F);

        wr(32'h00, 32'hA5A5_A5A5, 4'b0011);
        check("io_out_lo16", io_out[15:0], 64'hA5A5);
        rd_expect("out_lo", 32'h00, 32'h0000_A5A5);

        wr(32'h18, 32'h10, 4'hF);
        io_in[4] = 1'b1;
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge wb_clk_i);
            if (user_irq[1]) begin lat = c; break; end
        end
        check("irq_latency", lat, S + 2);
        rd_expect("is_lo_edge4", 32'h20, 32'h10);
        wr(32'h20, 32'h10, 4'hF);
        @(negedge wb_clk_i);
        check("irq_after_w1c", user_irq, 64'h0);

        wr(32'h28, 32'hFFFF_FFFE, 4'hF);
        wr(32'h18, 32'h11, 4'hF);
        io_in[0] = 1'b1;
        repeat (6) @(negedge wb_clk_i);
        rd_expect("is_lo_rise_pol0", 32'h20, 32'h0);
        io_in[0] = 1'b0;
        repeat (6) @(negedge wb_clk_i);
        rd_expect("is_lo_fall_pol0", 32'h20, 32'h1);
        check("irq0_fall", user_irq, 64'h1);

        io_in[4] = 1'b0;
        repeat (6) @(negedge wb_clk_i);
        io_in[4] = 1'b1;
        repeat (S - 1) @(negedge wb_clk_i);
        wr(32'h20, 32'h10, 4'hF);
        repeat (2) @(negedge wb_clk_i);
        rd_expect("is_set_wins", 32'h20, 32'h11);

        io_in = '1;
        do_reset();
        repeat (10) @(negedge wb_clk_i);
        rd_expect("is_lo_after_rst", 32'h20, 32'h0);
        rd_expect("is_hi_after_rst", 32'h24, 32'h0);
        rd_expect("in_lo_ones", 32'h10, 32'hFFFF_FFFF);
        check("irq_after_rst", user_irq, 64'h0);
        xfer(1'b1, BASE + 32'h100, 32'hFFFF_FFFF, 4'hF, rd, lat);
        check("miss_wr_lat", lat, 1);
        xfer(1'b0, BASE + 32'h100, 32'h0, 4'hF, rd, lat);
        check("miss_rd_lat", lat, 1);
        check("miss_rd_data", rd, 64'h0);
        rd_expect("out_lo_after_miss", 32'h00, 32'h0);

        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = BASE + 32'h08;
        @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b1;
        #1 check("ack_dropped", wbs_ack_o, 64'h0);
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        #2 wb_rst_i = 1'b0;
        repeat (2) @(negedge wb_clk_i);

        for (int t = 0; t < 400; t++) begin
            logic [31:0] a;
            if ($urandom_range(0, 2) == 0) begin
                r64 = {$urandom(), $urandom()};
                io_in = io_in ^ r64[37:0];
            end
            a = BASE + {24'd0, 4'($urandom_range(0, 13)), 2'b00};
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) a[31:8] = a[31:8] + 24'($urandom_range(1, 255));
            xfer(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)), rd, lat);
            repeat ($urandom_range(0, 3)) @(negedge wb_clk_i);
        end

        repeat (4) @(negedge wb_clk_i);
        check("queue_drained", exp_q.size(), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
